// File: rtl/ssg_lpf_bank.sv
// ssg_lpf_bank: time-multiplexed first-order IIR low-pass bank for SSG channel outputs.
// Optional build macro LPF_MIX_EN adds mix_out, the saturated sum of all channel outputs.
module ssg_lpf_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 16,
    parameter int COEF_W   = 18,
    parameter int NUM_SEL  = 4,
    parameter int DIV      = 256,
    localparam int SW      = $clog2(NUM_SEL)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [CHANNELS*SW-1:0]    sel,
    input  logic                      coef_we,
    input  logic [SW-1:0]             coef_addr,
    input  logic signed [COEF_W-1:0]  coef_a2,
    input  logic signed [COEF_W-1:0]  coef_b,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      overrun,
    output logic [2:0]                dbg_state
`ifdef LPF_MIX_EN
    ,
    output logic signed [WIDTH-1:0]   mix_out
`endif
);

    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NT    = 1 << SW;
    localparam int PW    = WIDTH + COEF_W + 1;
    localparam int ACC_W = WIDTH + COEF_W + 2;

    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] A2_DEF = COEF_W'(-32244);
    localparam logic signed [COEF_W-1:0] B_DEF  = COEF_W'(262);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_X = 3'd1,
        MUL_Y = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    logic [DW-1:0]           cnt;
    logic                    tick;
    state_t                  state;
    logic [CW-1:0]           ch;
    logic signed [ACC_W-1:0] acc;

    logic signed [WIDTH-1:0] x_s   [CHANNELS];
    logic [SW-1:0]           sel_s [CHANNELS];
    logic signed [WIDTH-1:0] x1_r  [CHANNELS];
    logic signed [WIDTH-1:0] y1_r  [CHANNELS];
    logic signed [WIDTH-1:0] out_r [CHANNELS];

    logic signed [COEF_W-1:0] a2_tab [NT];
    logic signed [COEF_W-1:0] b_tab  [NT];

    logic signed [WIDTH-1:0]  cur_x, cur_x1, cur_y1, y_flt, y_new;
    logic [SW-1:0]            cur_sel;
    logic signed [WIDTH:0]    xsum;
    logic signed [COEF_W-1:0] mul_a;
    logic signed [WIDTH:0]    mul_b;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  shifted;
    logic                     last_ch;

    assign cur_x   = x_s[ch];
    assign cur_x1  = x1_r[ch];
    assign cur_y1  = y1_r[ch];
    assign cur_sel = sel_s[ch];
    assign last_ch = (ch == CW'(CHANNELS - 1));
    assign xsum    = (WIDTH+1)'(cur_x) + (WIDTH+1)'(cur_x1);

    // The single shared multiplier: B*(x+x1) in MUL_X, A2*y1 in MUL_Y.
    always_comb begin
        mul_a = b_tab[cur_sel];
        mul_b = xsum;
        if (state == MUL_Y) begin
            mul_a = a2_tab[cur_sel];
            mul_b = (WIDTH+1)'(cur_y1);
        end
    end

    assign prod    = PW'(mul_a) * PW'(mul_b);
    assign shifted = acc >>> 15;

    always_comb begin
        if (shifted > Y_MAX)
            y_flt = Y_MAX[WIDTH-1:0];
        else if (shifted < Y_MIN)
            y_flt = Y_MIN[WIDTH-1:0];
        else
            y_flt = shifted[WIDTH-1:0];
        y_new = (cur_sel == '0) ? cur_x : y_flt;
    end

    // Free-running sample divider; tick is high for the one cycle in which cnt is back at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == DW'(DIV - 1));
            cnt  <= (cnt == DW'(DIV - 1)) ? '0 : cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NT; i++) begin
                a2_tab[i] <= A2_DEF;
                b_tab[i]  <= B_DEF;
            end
        end else if (coef_we && coef_addr != '0) begin
            a2_tab[coef_addr] <= coef_a2;
            b_tab[coef_addr]  <= coef_b;
        end
    end

    // out_valid is a single-cycle pulse in DONE; there is no back-pressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ch        <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                x_s[i]   <= '0;
                sel_s[i] <= '0;
                x1_r[i]  <= '0;
                y1_r[i]  <= '0;
                out_r[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (tick && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            x_s[i]   <= in[i*WIDTH +: WIDTH];
                            sel_s[i] <= sel[i*SW +: SW];
                        end
                        ch    <= '0;
                        state <= MUL_X;
                    end
                end
                MUL_X: begin
                    acc   <= ACC_W'(prod);
                    state <= MUL_Y;
                end
                MUL_Y: begin
                    acc   <= acc - ACC_W'(prod);
                    state <= WRITE;
                end
                WRITE: begin
                    x1_r[ch]  <= cur_x;
                    y1_r[ch]  <= y_new;
                    out_r[ch] <= y_new;
                    if (last_ch) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ch    <= ch + CW'(1);
                        state <= MUL_X;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_out
        assign out[gi*WIDTH +: WIDTH] = out_r[gi];
    end

    assign dbg_state = state;

`ifdef LPF_MIX_EN
    localparam int MW = WIDTH + $clog2(CHANNELS);
    localparam logic signed [MW-1:0] M_MAX = {{(MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [MW-1:0] M_MIN = {{(MW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [MW-1:0] mix_sum;

    // Summed on the last WRITE so mix_out appears together with out_valid.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CHANNELS - 1; i++)
            mix_sum = mix_sum + MW'(out_r[i]);
        mix_sum = mix_sum + MW'(y_new);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mix_out <= '0;
        end else if (state == WRITE && last_ch) begin
            if (mix_sum > M_MAX)
                mix_out <= M_MAX[WIDTH-1:0];
            else if (mix_sum < M_MIN)
                mix_out <= M_MIN[WIDTH-1:0];
            else
                mix_out <= mix_sum[WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_ssg_lpf_bank.sv
// Self-checking bench for ssg_lpf_bank: directed steps plus random frames against a reference model.
`timescale 1ns/1ps
module tb_ssg_lpf_bank;

    localparam int CH  = 3;
    localparam int W   = 16;
    localparam int NS  = 4;
    localparam int SWB = 2;
    localparam int DV  = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              reset_n, rst_o;
    logic [CH*W-1:0]   in_v, out_v, in_o, out_o;
    logic [CH*SWB-1:0] sel_v, sel_o;
    logic              coef_we;
    logic [SWB-1:0]    coef_addr;
    logic [17:0]       coef_a2, coef_b;
    logic              out_valid, overrun, ov_valid, ov_overrun;
    logic [2:0]        dbg_state, ov_state;
`ifdef LPF_MIX_EN
    logic [W-1:0]      mix_out, ov_mix;
`endif

    ssg_lpf_bank #(.CHANNELS(CH), .WIDTH(W), .COEF_W(18), .NUM_SEL(NS), .DIV(DV)) u_dut (
        .clk(clk), .reset_n(reset_n), .in(in_v), .sel(sel_v),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_a2(coef_a2), .coef_b(coef_b),
        .out(out_v), .out_valid(out_valid), .overrun(overrun), .dbg_state(dbg_state)
`ifdef LPF_MIX_EN
        , .mix_out(mix_out)
`endif
    );

    // Deliberately too-fast divider: frames take longer than one tick period.
    ssg_lpf_bank #(.CHANNELS(CH), .WIDTH(W), .COEF_W(18), .NUM_SEL(NS), .DIV(8)) u_ovr (
        .clk(clk), .reset_n(rst_o), .in(in_o), .sel(sel_o),
        .coef_we(1'b0), .coef_addr(2'd0), .coef_a2(18'd0), .coef_b(18'd0),
        .out(out_o), .out_valid(ov_valid), .overrun(ov_overrun), .dbg_state(ov_state)
`ifdef LPF_MIX_EN
        , .mix_out(ov_mix)
`endif
    );

    // scoreboard / reference model
    int          checks, errors, ref_cyc;
    logic [W-1:0] exp_q[$];
    logic [CH*W-1:0] last_out;
    longint a2_m[NS], b_m[NS], x1_m[CH], y1_m[CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint floor15(input longint v);
        longint q = v / 32768;
        if ((v % 32768) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            a2_m[s] = -32244;
            b_m[s]  = 262;
        end
        for (int c = 0; c < CH; c++) begin
            x1_m[c] = 0;
            y1_m[c] = 0;
        end
        last_out = '0;
    endtask

    task automatic model_frame();
        longint x, y;
        int s;
        for (int c = 0; c < CH; c++) begin
            x = longint'($signed(in_v[c*W +: W]));
            s = int'(sel_v[c*SWB +: SWB]);
            if (s == 0) y = x;
            else y = sat16(floor15(b_m[s] * (x + x1_m[c]) - a2_m[s] * y1_m[c]));
            x1_m[c] = x;
            y1_m[c] = y;
            exp_q.push_back(W'(y));
        end
    endtask

    // driver tasks
    task automatic set_ch(input int c, input int x, input int s);
        in_v[c*W +: W]      = W'(x);
        sel_v[c*SWB +: SWB] = SWB'(s);
    endtask

    task automatic rand_ch(input int c);
        int x;
        x = int'($urandom_range(0, 65535)) - 32768;
        set_ch(c, x, int'($urandom_range(0, NS - 1)));
    endtask

    task automatic write_coef(input int a, input int a2, input int b);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = SWB'(a); coef_a2 = 18'(a2); coef_b = 18'(b);
        @(negedge clk);
        coef_we = 1'b0;
        if (a != 0) begin
            a2_m[a] = a2;
            b_m[a]  = b;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (n == 3) check("hold", out_v, last_out);
            if (out_valid) break;
            if (n > 4 * DV) begin
                checks++; errors++;
                $error("FAIL timeout: no out_valid within %0d cycles", n);
                break;
            end
        end
    endtask

    task automatic frame(input string tag, input int exp_n);
        wait_valid();
        check({tag, "_period"}, cyc - ref_cyc, exp_n);
        ref_cyc = cyc;
        model_frame();
        for (int c = 0; c < CH; c++)
            check($sformatf("%s_ch%0d", tag, c), out_v[c*W +: W], exp_q.pop_front());
        check({tag, "_ovr"}, overrun, 1'b0);
        last_out = out_v;
    endtask

    initial begin
        int ov_cnt;
        checks = 0; errors = 0; ref_cyc = 0;
        reset_n = 1'b0; rst_o = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_a2 = '0; coef_b = '0;
        in_v = '0; sel_v = '0; in_o = '0; sel_o = '0;
        model_reset();
        set_ch(0, 10000, 1);
        repeat (3) @(negedge clk);
        check("rst_out", out_v, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovr", overrun, 0);

        // Step response of the default cutoff
        reset_n = 1'b1;
        ref_cyc = cyc;
        frame("t1_first", DV + 10);
        check("t1_f1_79", out_v[15:0], 79);
        rand_ch(1); rand_ch(2);
        frame("t1_f2", DV);
        check("t1_f2_237", out_v[15:0], 237);
        for (int k = 0; k < 600; k++) begin
            rand_ch(1); rand_ch(2);
            frame("t1_conv", DV);
            check("t1_no_overshoot", $signed(out_v[15:0]) <= 10000, 1'b1);
        end
        check("t1_settled", ($signed(out_v[15:0]) >= 9938) && ($signed(out_v[15:0]) <= 10000), 1'b1);

        // Bypass and bumpless switch back to filtering
        set_ch(0, 0, 0); rand_ch(1); rand_ch(2);
        frame("t2_zero", DV);
        set_ch(0, -12345, 0);
        frame("t2_step", DV);
        check("t2_bypass", out_v[15:0], 16'hCFC7);
        set_ch(0, -12345, 1);
        for (int k = 0; k < 5; k++) begin
            frame("t2_filt", DV);
            check("t2_no_step", ($signed(out_v[15:0]) >= -12346) && ($signed(out_v[15:0]) <= -12344), 1'b1);
        end

        // Averaging coefficient cancels an alternating input
        write_coef(2, 0, 16384);
        for (int k = 0; k < 6; k++) begin
            set_ch(1, (k % 2 == 1) ? -20000 : 20000, 2);
            rand_ch(2);
            frame("t3", DV);
            if (k > 0) check("t3_cancel", out_v[31:16], 0);
            check("t3_ch0_kept", out_v[15:0], 16'hCFC7);
        end

        // Saturation without wrap
        write_coef(3, -32767, 32767);
        for (int c = 0; c < CH; c++) set_ch(c, 32767, 3);
        for (int k = 0; k < 8; k++) begin
            frame("t4", DV);
            for (int c = 0; c < CH; c++) check("t4_no_wrap", out_v[c*W + W - 1], 1'b0);
        end
        check("t4_clamp", out_v, {CH{16'h7FFF}});

        // Random inputs, selects and coefficient rewrites
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                write_coef(int'($urandom_range(1, NS - 1)),
                           int'($urandom_range(0, 65535)) - 32768,
                           int'($urandom_range(0, 65535)) - 32768);
            for (int c = 0; c < CH; c++) rand_ch(c);
            frame("t5_rand", DV);
        end

        // Reset during MUL_Y of channel 1 (tick+5; next tick is DV-10 after out_valid)
        repeat (DV - 10 + 5) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t6_out", out_v, 0);
        check("t6_ovr", overrun, 0);
        check("t6_valid", out_valid, 0);
        model_reset();
        in_v = '0; sel_v = '0;
        set_ch(0, 10000, 1);
        @(negedge clk);
        reset_n = 1'b1;
        ref_cyc = cyc;
        frame("t6_first", DV + 10);
        check("t6_f1_79", out_v[15:0], 79);
        frame("t6_f2", DV);
        check("t6_f2_237", out_v[15:0], 237);

        // Illegal DIV: every second tick is dropped
        @(negedge clk);
        rst_o = 1'b1;
        ov_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (ov_valid) ov_cnt++;
            check($sformatf("t7_ovr_k%0d", k), ov_overrun, k >= 17);
        end
        check("t7_pulses", ov_cnt, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
